// File: rtl/uart_rcv_engine_if.sv
// Receive-side word handoff between uart_rcv_engine (master) and its consumer (slave).
interface uart_rcv_engine_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rcv_engine.sv
// Oversampling UART receiver: majority-voted bits, optional parity, 1-2 stop bits,
// single-entry output register with valid/ready handoff and overrun reporting.
module uart_rcv_engine #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               baud_tick,
  input  logic               serial_in,
  output logic               busy,
  uart_rcv_engine_if.master  rx
);

  localparam int unsigned M   = OVERSAMPLE / 2;
  localparam int unsigned SCW = $clog2(OVERSAMPLE);
  localparam int unsigned BCW = $clog2(DATA_BITS + 1);

  localparam logic [SCW-1:0] SC_CAP0 = SCW'(M - 1);
  localparam logic [SCW-1:0] SC_CAP1 = SCW'(M);
  localparam logic [SCW-1:0] SC_VOTE = SCW'(M + 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BC_DATA_END  = BCW'(DATA_BITS);
  localparam logic [BCW-1:0] BC_STOP_LAST = BCW'(STOP_BITS - 1);
  localparam logic           PAR_ON  = (PARITY_EN != 0);
  localparam logic           PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, rxs;
  logic [SCW-1:0]       sc_q, sc_d;
  logic [BCW-1:0]       bc_q, bc_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 cap0_q, cap0_d, cap1_q, cap1_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 in_frame_c, vote_c, vote_tick_c, wrap_c, commit_c;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      sync1_q <= serial_in;
      rxs     <= sync1_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    sc_d     = sc_q;
    bc_d     = bc_q;
    shift_d  = shift_q;
    cap0_d   = cap0_q;
    cap1_d   = cap1_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    commit_c = 1'b0;

    in_frame_c  = (state_q == START) || (state_q == DATA) ||
                  (state_q == PARITY) || (state_q == STOP);
    vote_c      = (cap0_q & cap1_q) | (cap0_q & rxs) | (cap1_q & rxs);
    vote_tick_c = baud_tick && in_frame_c && (sc_q == SC_VOTE);
    wrap_c      = (sc_q == SC_LAST);

    if (baud_tick) begin
      // Bit-period sample counter and the two early majority captures.
      if (in_frame_c) begin
        sc_d = wrap_c ? '0 : sc_q + SCW'(1);
        if (sc_q == SC_CAP0) cap0_d = rxs;
        if (sc_q == SC_CAP1) cap1_d = rxs;
      end

      case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_d = START;
            sc_d    = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end
        START: begin
          if (vote_tick_c && vote_c) begin
            state_d = IDLE;
            sc_d    = '0;
          end else if (wrap_c) begin
            state_d = DATA;
            bc_d    = '0;
          end
        end
        DATA: begin
          if (vote_tick_c) begin
            shift_d = {vote_c, shift_q[DATA_BITS-1:1]};
            bc_d    = bc_q + BCW'(1);
          end
          if (wrap_c && (bc_q == BC_DATA_END)) begin
            state_d = PAR_ON ? PARITY : STOP;
            bc_d    = '0;
          end
        end
        PARITY: begin
          if (vote_tick_c) perr_d = (vote_c != ((^shift_q) ^ PAR_ODD));
          if (wrap_c) begin
            state_d = STOP;
            bc_d    = '0;
          end
        end
        STOP: begin
          // Commit on the last stop vote so the next start edge is not missed.
          if (vote_tick_c) begin
            ferr_d = ferr_q | ~vote_c;
            if (bc_q == BC_STOP_LAST) begin
              commit_c = 1'b1;
              sc_d     = '0;
              state_d  = (ferr_q | ~vote_c) ? WAIT_HIGH : IDLE;
            end else begin
              bc_d = bc_q + BCW'(1);
            end
          end
        end
        WAIT_HIGH: begin
          if (rxs) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      sc_q    <= '0;
      bc_q    <= '0;
      shift_q <= '0;
      cap0_q  <= 1'b1;
      cap1_q  <= 1'b1;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      bc_q    <= bc_d;
      shift_q <= shift_d;
      cap0_q  <= cap0_d;
      cap1_q  <= cap1_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      busy    <= (state_d != IDLE);
    end
  end

  // Single-entry output register; a commit may land in the same cycle as the handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx.rx_data    <= '0;
      rx.rx_valid   <= 1'b0;
      rx.parity_err <= 1'b0;
      rx.frame_err  <= 1'b0;
      rx.overrun    <= 1'b0;
    end else begin
      rx.overrun <= 1'b0;
      if (commit_c) begin
        if (!rx.rx_valid || rx.rx_ready) begin
          rx.rx_data    <= shift_q;
          rx.parity_err <= PAR_ON & perr_q;
          rx.frame_err  <= ferr_d;
          rx.rx_valid   <= 1'b1;
        end else begin
          rx.overrun <= 1'b1;
        end
      end else if (rx.rx_valid && rx.rx_ready) begin
        rx.rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rcv_engine.sv
// Directed bench for uart_rcv_engine: three parameterisations driven by one shared tick.
module tb_uart_rcv_engine;

  logic clk = 1'b0;
  logic rstn, rstn2, tick;
  logic sl0, sl1, sl2;
  logic busy0, busy1, busy2;
  int   tcnt = 0;
  int   total = 0, passed = 0;

  int acc0 = 0, acc1 = 0, acc2 = 0, ovr0 = 0;
  int run0 = 0, max0 = 0;
  logic [7:0] d0 = '0, d1 = '0;
  logic [4:0] d2 = '0;
  logic pe0 = 0, fe0 = 0, pe1 = 0, fe1 = 0, fe2 = 0;

  uart_rcv_engine_if #(.DATA_BITS(8)) if0 ();
  uart_rcv_engine_if #(.DATA_BITS(8)) if1 ();
  uart_rcv_engine_if #(.DATA_BITS(5)) if2 ();

  uart_rcv_engine u0 (.clk(clk), .rstn(rstn), .baud_tick(tick), .serial_in(sl0),
                      .busy(busy0), .rx(if0));
  uart_rcv_engine #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0),
                    .STOP_BITS(2))
    u1 (.clk(clk), .rstn(rstn), .baud_tick(tick), .serial_in(sl1), .busy(busy1), .rx(if1));
  uart_rcv_engine #(.DATA_BITS(5), .OVERSAMPLE(8))
    u2 (.clk(clk), .rstn(rstn2), .baud_tick(tick), .serial_in(sl2), .busy(busy2), .rx(if2));

  always #5 clk = ~clk;

  // One baud_tick every third clock.
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = (tcnt == 0);
      tcnt = (tcnt + 1) % 3;
    end
  end

  // Record accepted words, overrun pulses and busy run length just after each negedge.
  always @(negedge clk) begin
    #1;
    if (if0.rx_valid && if0.rx_ready) begin
      acc0++; d0 = if0.rx_data; pe0 = if0.parity_err; fe0 = if0.frame_err;
    end
    if (if0.overrun) ovr0++;
    if (if1.rx_valid && if1.rx_ready) begin
      acc1++; d1 = if1.rx_data; pe1 = if1.parity_err; fe1 = if1.frame_err;
    end
    if (if2.rx_valid && if2.rx_ready) begin
      acc2++; d2 = if2.rx_data; fe2 = if2.frame_err;
    end
    if (busy0) begin
      run0++;
      if (run0 > max0) max0 = run0;
    end else begin
      run0 = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (tick !== 1'b1) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic drive(input int idx, input logic v, input int n);
    case (idx)
      0:       sl0 = v;
      1:       sl1 = v;
      default: sl2 = v;
    endcase
    wait_ticks(n);
  endtask

  task automatic send_frame(input int idx, input int os, input int nbits,
                            input logic [8:0] data, input bit par_en, input logic par_bit,
                            input int nstop, input logic [1:0] stops);
    drive(idx, 1'b0, os);
    for (int i = 0; i < nbits; i++) drive(idx, data[i], os);
    if (par_en) drive(idx, par_bit, os);
    for (int i = 0; i < nstop; i++) drive(idx, stops[i], os);
  endtask

  initial begin
    rstn = 1'b0; rstn2 = 1'b0;
    sl0 = 1'b1; sl1 = 1'b1; sl2 = 1'b1;
    if0.rx_ready = 1'b1; if1.rx_ready = 1'b1; if2.rx_ready = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_valid",   32'(if0.rx_valid),   32'd0);
    chk("rst_data",    32'(if0.rx_data),    32'd0);
    chk("rst_busy",    32'(busy0),          32'd0);
    chk("rst_overrun", 32'(if0.overrun),    32'd0);
    chk("rst_ferr",    32'(if0.frame_err),  32'd0);
    chk("rst_perr",    32'(if0.parity_err), 32'd0);
    rstn = 1'b1; rstn2 = 1'b1;
    wait_ticks(4);

    // Basic frame 0xA5.
    send_frame(0, 16, 8, 9'h0A5, 1'b0, 1'b0, 1, 2'b11);
    wait_ticks(4);
    chk("a5_count", 32'(acc0), 32'd1);
    chk("a5_data",  32'(d0),   32'hA5);
    chk("a5_perr",  32'(pe0),  32'd0);
    chk("a5_ferr",  32'(fe0),  32'd0);
    chk("a5_busy",  32'(busy0), 32'd0);

    // One-tick low glitch on an idle line.
    max0 = 0;
    drive(0, 1'b0, 1);
    sl0 = 1'b1;
    wait_ticks(30);
    chk("glitch_busy_max", 32'(max0 <= 30), 32'd1);
    chk("glitch_busy_seen", 32'(max0 >= 3), 32'd1);
    chk("glitch_no_word", 32'(acc0), 32'd1);
    chk("glitch_idle", 32'(busy0), 32'd0);

    // Back-pressure: second frame overruns, third commits alongside the handshake.
    if0.rx_ready = 1'b0;
    send_frame(0, 16, 8, 9'h011, 1'b0, 1'b0, 1, 2'b11);
    wait_ticks(4);
    chk("ovr_hold_valid", 32'(if0.rx_valid), 32'd1);
    chk("ovr_first_data", 32'(if0.rx_data),  32'h11);
    send_frame(0, 16, 8, 9'h022, 1'b0, 1'b0, 1, 2'b11);
    wait_ticks(4);
    chk("ovr_kept_data", 32'(if0.rx_data), 32'h11);
    chk("ovr_pulse",     32'(ovr0),        32'd1);
    fork
      send_frame(0, 16, 8, 9'h033, 1'b0, 1'b0, 1, 2'b11);
      begin
        wait_ticks(154);
        repeat (2) @(negedge clk);
        if0.rx_ready = 1'b1;
        @(negedge clk);
        if0.rx_ready = 1'b0;
      end
    join
    wait_ticks(4);
    chk("same_cyc_data",    32'(if0.rx_data),  32'h33);
    chk("same_cyc_no_ovr",  32'(ovr0),         32'd1);
    chk("same_cyc_valid",   32'(if0.rx_valid), 32'd1);
    chk("same_cyc_acc",     32'(acc0),         32'd2);
    chk("same_cyc_acc_dat", 32'(d0),           32'h11);
    if0.rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("drain_valid", 32'(if0.rx_valid), 32'd0);
    chk("drain_acc",   32'(acc0),         32'd3);
    chk("drain_data",  32'(d0),           32'h33);

    // Parity and two stop bits.
    send_frame(1, 16, 8, 9'h007, 1'b1, 1'b0, 2, 2'b11);
    wait_ticks(4);
    chk("par_bad_count", 32'(acc1), 32'd1);
    chk("par_bad_data",  32'(d1),   32'h07);
    chk("par_bad_perr",  32'(pe1),  32'd1);
    chk("par_bad_ferr",  32'(fe1),  32'd0);
    send_frame(1, 16, 8, 9'h007, 1'b1, 1'b1, 2, 2'b11);
    wait_ticks(4);
    chk("par_ok_count", 32'(acc1), 32'd2);
    chk("par_ok_perr",  32'(pe1),  32'd0);
    send_frame(1, 16, 8, 9'h03C, 1'b1, 1'b0, 2, 2'b01);
    sl1 = 1'b1;
    wait_ticks(4);
    chk("stop2_count", 32'(acc1), 32'd3);
    chk("stop2_data",  32'(d1),   32'h3C);
    chk("stop2_ferr",  32'(fe1),  32'd1);
    chk("stop2_perr",  32'(pe1),  32'd0);

    // Break: line low for three frame times yields exactly one word.
    drive(1, 1'b0, 576);
    chk("brk_count", 32'(acc1),  32'd4);
    chk("brk_data",  32'(d1),    32'h00);
    chk("brk_ferr",  32'(fe1),   32'd1);
    chk("brk_wait",  32'(busy1), 32'd1);
    drive(1, 1'b1, 20);
    chk("brk_release_count", 32'(acc1),  32'd4);
    chk("brk_release_idle",  32'(busy1), 32'd0);
    send_frame(1, 16, 8, 9'h05A, 1'b1, 1'b0, 2, 2'b11);
    wait_ticks(4);
    chk("post_brk_count", 32'(acc1), 32'd5);
    chk("post_brk_data",  32'(d1),   32'h5A);
    chk("post_brk_ferr",  32'(fe1),  32'd0);

    // Reset in the middle of data bits, then a clean 5-bit frame.
    drive(2, 1'b0, 8);
    drive(2, 1'b1, 8);
    drive(2, 1'b1, 4);
    chk("midrst_busy_before", 32'(busy2), 32'd1);
    rstn2 = 1'b0;
    sl2 = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_busy",  32'(busy2),        32'd0);
    chk("midrst_valid", 32'(if2.rx_valid), 32'd0);
    rstn2 = 1'b1;
    wait_ticks(20);
    chk("midrst_no_word", 32'(acc2), 32'd0);
    send_frame(2, 8, 5, 9'h015, 1'b0, 1'b0, 1, 2'b11);
    wait_ticks(4);
    chk("db5_count", 32'(acc2), 32'd1);
    chk("db5_data",  32'(d2),   32'h15);
    chk("db5_ferr",  32'(fe2),  32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
